// File: rtl/ula_arbiter_pkg.sv
// Shared constants and types for the ula arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ula_arbiter_pkg;

  // Default widths for operands/result and operation code.
  localparam int BITS_DEF   = 8;
  localparam int ULA_OP_DEF = 4;

  // ula operation codes.
  localparam int OP_ADD   = 0;
  localparam int OP_AND   = 1;
  localparam int OP_OR    = 2;
  localparam int OP_XOR   = 3;
  localparam int OP_SUB   = 4;
  localparam int OP_NOT   = 5;
  localparam int OP_SHL   = 6;
  localparam int OP_SHR   = 7;
  localparam int OP_PASSA = 8;
  localparam int OP_PASSB = 9;

  // Requester ids: execute path and PC/address incrementer.
  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_PC   = 1'b1;

  // Response buffer occupancy; the encoding doubles as rsp_valid_out.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;

  // Round-robin pick: a lone valid requester wins, a tie goes to the one
  // that was not granted last.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
    return (v0 & v1) ? ~last : v1;
  endfunction

endpackage

// File: rtl/ula_arbiter_ula.sv
// Combinational ula: one result per op/a/b, no carry or overflow outputs.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the result follows the inputs.
module ula
  import ula_arbiter_pkg::*;
#(
  parameter int ULA_OP = ULA_OP_DEF,
  parameter int BITS   = BITS_DEF
) (
  input  logic [ULA_OP-1:0] op_in,
  input  logic [BITS-1:0]   a_in,
  input  logic [BITS-1:0]   b_in,
  output logic [BITS-1:0]   result_out
);

  // Decode the op code; unknown codes produce zero.
  always_comb begin
    result_out = '0;
    case (op_in)
      ULA_OP'(OP_ADD):   result_out = a_in + b_in;
      ULA_OP'(OP_AND):   result_out = a_in & b_in;
      ULA_OP'(OP_OR):    result_out = a_in | b_in;
      ULA_OP'(OP_XOR):   result_out = a_in ^ b_in;
      ULA_OP'(OP_SUB):   result_out = a_in - b_in;
      ULA_OP'(OP_NOT):   result_out = ~a_in;
      ULA_OP'(OP_SHL):   result_out = a_in << 1;
      ULA_OP'(OP_SHR):   result_out = a_in >> 1;
      ULA_OP'(OP_PASSA): result_out = a_in;
      ULA_OP'(OP_PASSB): result_out = b_in;
      default:           result_out = '0;
    endcase
  end

endmodule

// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one ula between the execute path and the PC incrementer.
// Latency: accept on a clock edge, result visible in the response buffer right after it.
// Backpressure: one-deep response buffer; readies drop while it is full and not drained.
module ula_arbiter
  import ula_arbiter_pkg::*;
#(
  parameter int BITS   = BITS_DEF,
  parameter int ULA_OP = ULA_OP_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req0_valid_in,
  input  logic [ULA_OP-1:0] req0_op_in,
  input  logic [BITS-1:0]   req0_a_in,
  input  logic [BITS-1:0]   req0_b_in,
  output logic              req0_ready_out,
  input  logic              req1_valid_in,
  input  logic [ULA_OP-1:0] req1_op_in,
  input  logic [BITS-1:0]   req1_a_in,
  input  logic [BITS-1:0]   req1_b_in,
  output logic              req1_ready_out,
  output logic              rsp_valid_out,
  output logic              rsp_id_out,
  output logic [BITS-1:0]   rsp_result_out,
  input  logic              rsp_ready_in
);

  rsp_state_t        state;
  rsp_state_t        state_next;
  logic              last_grant;
  logic              grant_any;
  logic              grant_id;
  logic              can_accept;
  logic              accept;
  logic [ULA_OP-1:0] ula_op;
  logic [BITS-1:0]   ula_a;
  logic [BITS-1:0]   ula_b;
  logic [BITS-1:0]   ula_result;

  // Grant selection and handshake: the buffer can take a new result when
  // empty or when its current result leaves on this same edge.
  always_comb begin
    grant_any      = req0_valid_in | req1_valid_in;
    grant_id       = rr_pick(req0_valid_in, req1_valid_in, last_grant);
    can_accept     = (state == EMPTY) | rsp_ready_in;
    accept         = can_accept & grant_any;
    req0_ready_out = accept & (grant_id == REQ_EXEC);
    req1_ready_out = accept & (grant_id == REQ_PC);
  end

  // Operand mux; with no grant, grant_id is 0 so requester 0 drives the ula.
  always_comb begin
    ula_op = req0_op_in;
    ula_a  = req0_a_in;
    ula_b  = req0_b_in;
    if (grant_id == REQ_PC) begin
      ula_op = req1_op_in;
      ula_a  = req1_a_in;
      ula_b  = req1_b_in;
    end
  end

  ula #(
    .ULA_OP(ULA_OP),
    .BITS  (BITS)
  ) u_ula (
    .op_in     (ula_op),
    .a_in      (ula_a),
    .b_in      (ula_b),
    .result_out(ula_result)
  );

  // Buffer occupancy register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= EMPTY;
    else        state <= state_next;
  end

  // Occupancy next state: fill on accept, drain when consumed with nothing new.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (!accept && rsp_ready_in) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Response payload and round-robin history; both move only on an accept,
  // so a requester that drops valid keeps its turn.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rsp_result_out <= '0;
      rsp_id_out     <= 1'b0;
      last_grant     <= 1'b1;
    end else if (accept) begin
      rsp_result_out <= ula_result;
      rsp_id_out     <= grant_id;
      last_grant     <= grant_id;
    end
  end

  assign rsp_valid_out = (state == FULL);

endmodule

// File: tb/tb_ula_arbiter.sv
// Self-checking bench for ula_arbiter: directed table, reset/corner sequences,
// an exhaustive AND sweep on requester 1, and constrained-random traffic
// compared against a behavioural model.
`timescale 1ns/1ps
module tb_ula_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0v = 1'b0;
  logic [3:0] r0op = '0;
  logic [7:0] r0a = '0;
  logic [7:0] r0b = '0;
  logic       r0r;
  logic       r1v = 1'b0;
  logic [3:0] r1op = '0;
  logic [7:0] r1a = '0;
  logic [7:0] r1b = '0;
  logic       r1r;
  logic       rv;
  logic       rid;
  logic [7:0] rres;
  logic       rrdy = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ula_arbiter #(.BITS(8), .ULA_OP(4)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req0_valid_in (r0v),
    .req0_op_in    (r0op),
    .req0_a_in     (r0a),
    .req0_b_in     (r0b),
    .req0_ready_out(r0r),
    .req1_valid_in (r1v),
    .req1_op_in    (r1op),
    .req1_a_in     (r1a),
    .req1_b_in     (r1b),
    .req1_ready_out(r1r),
    .rsp_valid_out (rv),
    .rsp_id_out    (rid),
    .rsp_result_out(rres),
    .rsp_ready_in  (rrdy)
  );

  typedef struct {
    logic       v0;
    logic [3:0] op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic [3:0] op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rdy;
    logic       e_r0;
    logic       e_r1;
    logic       e_vld;
    logic       e_id;
    logic [7:0] e_res;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: buffer contents and who was served last.
  bit         m_full;
  bit         m_id;
  logic [7:0] m_res;
  bit         m_last;

  function automatic vec_t mk(input logic v0, input logic [3:0] op0, input logic [7:0] a0,
                              input logic [7:0] b0, input logic v1, input logic [3:0] op1,
                              input logic [7:0] a1, input logic [7:0] b1, input logic rdy,
                              input logic e_r0, input logic e_r1, input logic e_vld,
                              input logic e_id, input logic [7:0] e_res);
    vec_t v;
    v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1;
    v.rdy = rdy; v.e_r0 = e_r0; v.e_r1 = e_r1;
    v.e_vld = e_vld; v.e_id = e_id; v.e_res = e_res;
    return v;
  endfunction

  function automatic logic [7:0] ref_ula(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = (a + b) % 256;
      1: r = a & b;
      2: r = a | b;
      3: r = a ^ b;
      4: r = (a - b + 256) % 256;
      5: r = 255 - a;
      6: r = (a * 2) % 256;
      7: r = a / 2;
      8: r = a;
      9: r = b;
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // Who gets served this cycle (-1 for nobody): the requester that was not
  // served last has priority, the other one goes if it is alone.
  function automatic int ref_pick(input bit v0, input bit v1, input bit rdy);
    bit want[2];
    int pref;
    want[0] = v0;
    want[1] = v1;
    if (m_full && !rdy) return -1;
    pref = m_last ? 0 : 1;
    if (want[pref]) return pref;
    if (want[1 - pref]) return 1 - pref;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 0;
    m_id   = 0;
    m_res  = '0;
    m_last = 1;
  endtask

  // Called just after a rising edge: drive, check readies at the falling
  // edge, advance the model on the rising edge, check the buffer after it.
  task automatic step(input vec_t v, input bit use_tbl, output int pick);
    r0v = v.v0; r0op = v.op0; r0a = v.a0; r0b = v.b0;
    r1v = v.v1; r1op = v.op1; r1a = v.a1; r1b = v.b1;
    rrdy = v.rdy;
    @(negedge clk);
    pick = ref_pick(v.v0, v.v1, v.rdy);
    check("req0_ready", r0r, pick == 0);
    check("req1_ready", r1r, pick == 1);
    if (use_tbl) begin
      check("tbl_req0_ready", r0r, v.e_r0);
      check("tbl_req1_ready", r1r, v.e_r1);
    end
    @(posedge clk);
    if (pick == 0) begin
      m_res = ref_ula(v.op0, v.a0, v.b0); m_id = 0; m_full = 1; m_last = 0;
    end else if (pick == 1) begin
      m_res = ref_ula(v.op1, v.a1, v.b1); m_id = 1; m_full = 1; m_last = 1;
    end else if (m_full && v.rdy) begin
      m_full = 0;
    end
    #1;
    check("rsp_valid", rv, m_full);
    check("rsp_id", rid, m_id);
    check("rsp_result", rres, m_res);
    if (use_tbl) begin
      check("tbl_rsp_valid", rv, v.e_vld);
      check("tbl_rsp_id", rid, v.e_id);
      check("tbl_rsp_result", rres, v.e_res);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   pick;
    vec_t v;
    vec_t cur0;
    vec_t cur1;
    bit   hold0;
    bit   hold1;

    // Directed table: v0 op0 a0 b0 | v1 op1 a1 b1 | rdy | r0 r1 | vld id res
    // Tie right after reset: grants 0,1,0,1.
    tbl.push_back(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 1, 0, 1, 0, 8'h0F));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 0, 1, 1, 1, 8'hAA));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 1, 0, 1, 0, 8'h0F));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 0, 1, 1, 1, 8'hAA));
    // Idle drain: valid drops, id/result hold.
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'hAA));
    // Single requester 0: AND F0,3C -> 30.
    tbl.push_back(mk(1, 1, 8'hF0, 8'h3C, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'h30));
    // Backpressure three cycles with req1 waiting, then pass-through.
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'hFF, 0, 0, 0, 1, 0, 8'h30));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'hFF, 0, 0, 0, 1, 0, 8'h30));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'hFF, 0, 0, 0, 1, 0, 8'h30));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h55, 8'hFF, 1, 0, 1, 1, 1, 8'h55));
    // Turn retention: req0 alone twice, then a tie goes to req1.
    tbl.push_back(mk(1, 1, 8'h0F, 8'hF0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'h00));
    tbl.push_back(mk(1, 2, 8'h0F, 8'hF0, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1, 0, 8'hFF));
    tbl.push_back(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 0, 1, 1, 1, 8'hAA));
    // Full and stalled, then drained.
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1, 1, 8'hAA));
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 1, 8'hAA));

    // Reset state.
    model_reset();
    #12;
    check("reset_rsp_valid", rv, 1'b0);
    check("reset_rsp_id", rid, 1'b0);
    check("reset_rsp_result", rres, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], 1'b1, pick);

    // Reset while full: req1 XOR 5A,FF -> A5 is buffered first.
    step(mk(0, 0, 8'h00, 8'h00, 1, 3, 8'h5A, 8'hFF, 1, 0, 1, 1, 1, 8'hA5), 1'b1, pick);
    r0v = 1'b0; r1v = 1'b0; rrdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midreset_rsp_valid", rv, 1'b0);
    check("midreset_rsp_result", rres, 8'h00);
    check("midreset_rsp_id", rid, 1'b0);
    model_reset();
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step(mk(1, 1, 8'hFF, 8'h0F, 1, 1, 8'hAA, 8'hFF, 1, 1, 0, 1, 0, 8'h0F), 1'b1, pick);

    // Exhaustive AND sweep through requester 1.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        v = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'(a), 8'(b), 1, 0, 0, 0, 0, 8'h00);
        step(v, 1'b0, pick);
      end
    end

    // Random traffic; a requester not accepted keeps its request unchanged.
    hold0 = 0;
    hold1 = 0;
    cur0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cur1 = cur0;
    for (int n = 0; n < 3000; n++) begin
      if (!hold0) begin
        cur0.v0  = ($urandom_range(0, 3) != 0);
        cur0.op0 = 4'($urandom_range(0, 11));
        cur0.a0  = 8'($urandom_range(0, 255));
        cur0.b0  = 8'($urandom_range(0, 255));
      end
      if (!hold1) begin
        cur1.v1  = ($urandom_range(0, 3) != 0);
        cur1.op1 = 4'($urandom_range(0, 11));
        cur1.a1  = 8'($urandom_range(0, 255));
        cur1.b1  = 8'($urandom_range(0, 255));
      end
      v = cur0;
      v.v1  = cur1.v1;
      v.op1 = cur1.op1;
      v.a1  = cur1.a1;
      v.b1  = cur1.b1;
      v.rdy = ($urandom_range(0, 3) != 0);
      step(v, 1'b0, pick);
      hold0 = v.v0 && (pick != 0);
      hold1 = v.v1 && (pick != 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
